inst_mem_loader: RTL and testbench

Sequencer that fills the program instruction memory from a byte stream (UART receiver output) before the MIPS core runs. Assembles four bytes per 32-bit instruction, drives the memory's address, data and write strobe with setup before the strobe edge, and stops after writing the HALT instruction (opcode 111111) or the last memory entry. After loading, it releases the memory address port to the core's program counter.

---
 rtl/inst_mem_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: fills the program instruction memory from a UART byte stream.
// Bytes are assembled MSB-first into 32-bit instructions. Each instruction is
// presented with a full setup cycle before a one-cycle write strobe. A load ends
// after the HALT instruction (opcode 6'b111111) is written, or after the last
// memory entry is written (overflow). Outside a load the memory address port
// follows the core's program counter.
//
// Optional feature: define LOADER_CHECKSUM_EN to add a trailing checksum byte
// after HALT. That byte is compared with the XOR of all instruction bytes and
// the result is reported on chk_err.

module inst_mem_loader #(
    parameter int LEN_ADDR  = 7,
    parameter int LEN_DATA  = 32,
    parameter int RAM_DEPTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic [LEN_ADDR-1:0] cpu_addr,
    output logic [LEN_ADDR-1:0] mem_addr,
    output logic [LEN_DATA-1:0] mem_data,
    output logic                mem_wr,
    output logic                busy,
    output logic                load_done,
    output logic                ovf,
    output logic [LEN_ADDR:0]   word_count,
    output logic                chk_err
);

    localparam logic [LEN_ADDR-1:0] LAST_ADDR = LEN_ADDR'(RAM_DEPTH - 1);
    localparam logic [LEN_ADDR-1:0] ADDR_ONE  = LEN_ADDR'(1);
    localparam logic [LEN_ADDR:0]   COUNT_ONE = (LEN_ADDR + 1)'(1);
    localparam logic [5:0]          HALT_OP   = 6'b111111;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        SETUP,
        STROBE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // The three most recent bytes. Together with the incoming byte they form
    // a full instruction.
    logic [23:0]         word_reg;
    logic [1:0]          byte_cnt;
    logic [LEN_ADDR-1:0] load_addr;

    logic start_accept;
    logic byte_capture;
    logic word_complete;
    logic is_halt;
    logic is_loading;
    logic entering_done;

    // A new load is accepted only while the loader is idle or has finished.
    // A load_start pulse that arrives during a load is ignored.
    assign start_accept  = load_start && (state == IDLE || state == DONE);

    // Bytes are taken in RECV, SETUP and STROBE. Bytes that arrive during the
    // write of the previous word count toward the next word, so back-to-back
    // bytes are never lost.
    assign byte_capture  = rx_done && (state == RECV || state == SETUP || state == STROBE);

    // Only RECV can complete a word. At most two bytes can arrive during SETUP
    // and STROBE, so the fourth byte of a word always arrives in RECV.
    assign word_complete = rx_done && (state == RECV) && (byte_cnt == 2'd3);

    // The HALT check uses the held copy of the word. That copy stays stable
    // while new bytes shift into word_reg.
    assign is_halt       = (mem_data[LEN_DATA-1 -: 6] == HALT_OP);

    assign entering_done = (next_state == DONE) && (state != DONE);

    // The loader owns the address port for the whole load. Otherwise the core's
    // PC drives it. The select is combinational; the state is registered.
    assign is_loading = (state == RECV) || (state == SETUP) || (state == STROBE)
`ifdef LOADER_CHECKSUM_EN
                        || (state == CHECK)
`endif
                        ;

    assign mem_addr = is_loading ? load_addr : cpu_addr;

    // The strobe is a registered-state decode, so it is high for exactly the
    // one STROBE cycle.
    assign mem_wr = (state == STROBE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: sequencing of receive, setup, strobe and termination
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                if (word_complete) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = STROBE;
            end
            STROBE: begin
                if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = DONE;
`endif
                end else if (load_addr == LAST_ADDR) begin
                    next_state = DONE;
                end else begin
                    next_state = RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_done) begin
                    next_state = DONE;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Byte assembly: shift-in of received bytes and byte counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_reg <= '0;
            byte_cnt <= 2'd0;
        end else if (start_accept) begin
            word_reg <= '0;
            byte_cnt <= 2'd0;
        end else if (byte_capture) begin
            word_reg <= {word_reg[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Write data hold register. It is loaded once per word and is independent
    // of word_reg, so data stays stable through SETUP and STROBE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_data <= '0;
        end else if (word_complete) begin
            mem_data <= {word_reg, rx_data};
        end
    end

    // Load address and word count. The address stops at the last entry and
    // never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_addr  <= '0;
            word_count <= '0;
        end else if (start_accept) begin
            load_addr  <= '0;
            word_count <= '0;
        end else if (state == STROBE) begin
            word_count <= word_count + COUNT_ONE;
            if (!is_halt && (load_addr != LAST_ADDR)) begin
                load_addr <= load_addr + ADDR_ONE;
            end
        end
    end

    // Status flags: busy during a load, load_done after it, and ovf when the
    // memory filled up before a HALT arrived
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            load_done <= 1'b0;
            ovf       <= 1'b0;
        end else if (start_accept) begin
            busy      <= 1'b1;
            load_done <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (state == STROBE && !is_halt && load_addr == LAST_ADDR) begin
                ovf <= 1'b1;
            end
            if (entering_done) begin
                busy      <= 1'b0;
                load_done <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
    logic       chk_err_q;

    // Running XOR of every instruction byte. The trailing byte received in
    // CHECK is compared with this XOR; that byte is not shifted into the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum  <= 8'h00;
            chk_err_q <= 1'b0;
        end else if (start_accept) begin
            checksum  <= 8'h00;
            chk_err_q <= 1'b0;
        end else begin
            if (byte_capture) begin
                checksum <= checksum ^ rx_data;
            end
            if (state == CHECK && rx_done) begin
                chk_err_q <= (rx_data != checksum);
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader. The stimulus pushes each expected
// memory write into a queue. A monitor pops an entry and compares it on every
// mem_wr pulse. It also checks that address and data were stable during the
// cycle before the strobe.

module tb_inst_mem_loader;

    localparam int LEN_ADDR = 7;

    logic                clk = 1'b0;
    logic                reset;
    logic                load_start;
    logic [7:0]          rx_data;
    logic                rx_done;
    logic [LEN_ADDR-1:0] cpu_addr;
    logic [LEN_ADDR-1:0] mem_addr;
    logic [31:0]         mem_data;
    logic                mem_wr;
    logic                busy;
    logic                load_done;
    logic                ovf;
    logic [LEN_ADDR:0]   word_count;
    logic                chk_err;

    inst_mem_loader #(.LEN_ADDR(7), .LEN_DATA(32), .RAM_DEPTH(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .cpu_addr   (cpu_addr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .load_done  (load_done),
        .ovf        (ovf),
        .word_count (word_count),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  csum;
    logic [6:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        prev_wr   = 1'b0;

    // Write monitor: sampled 1 ns after each rising edge
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (mem_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write actual addr=%0h data=%08h required no write",
                         mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_data !== e.data) begin
                    failures++;
                    $display("[TB] FAIL write actual addr=%0h data=%08h required addr=%0h data=%08h",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
            checks++;
            if (prev_wr !== 1'b0 || prev_addr !== mem_addr || prev_data !== mem_data) begin
                failures++;
                $display("[TB] FAIL setup actual prev_wr=%0b prev addr=%0h data=%08h required 0 and addr=%0h data=%08h",
                         prev_wr, prev_addr, prev_data, mem_addr, mem_data);
            end
        end
        prev_addr = mem_addr;
        prev_data = mem_data;
        prev_wr   = mem_wr;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Presents one byte for one cycle. Called and returns on a falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        csum = 8'h00;
    endtask

    task automatic sendWord(input logic [6:0] addr, input logic [31:0] w, input int gap);
        wr_t e;
        e.addr = addr;
        e.data = w;
        exp_q.push_back(e);
        for (int i = 3; i >= 0; i--) begin
            csum = csum ^ w[i*8 +: 8];
            applyStimulus(w[i*8 +: 8]);
            idle(gap);
        end
    endtask

    // In the checksum build a HALT load ends only after the trailing byte.
    // good=0 sends a byte that differs from the running XOR.
    task automatic finishHalt(input bit good);
`ifdef LOADER_CHECKSUM_EN
        idle(5);
        checkOutput("done_before_chk_byte", {31'd0, load_done}, 32'd0);
        applyStimulus(good ? csum : (csum ^ 8'hFF));
`else
        if (!good) idle(1);
`endif
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (load_done === 1'b1) break;
            @(negedge clk);
        end
        checkOutput("load_done_timeout", {31'd0, load_done}, 32'd1);
    endtask

    task automatic checkResetValues(input logic [6:0] pc);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_mem_data", mem_data, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
        checkOutput("rst_chk_err", {31'd0, chk_err}, 32'd0);
        checkOutput("rst_word_count", {24'd0, word_count}, 32'd0);
        checkOutput("rst_mem_addr", {25'd0, mem_addr}, {25'd0, pc});
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        rx_data    = 8'h00;
        rx_done    = 1'b0;
        cpu_addr   = 7'h33;
        csum       = 8'h00;
        idle(2);
        checkResetValues(7'h33);
        reset = 1'b0;
        idle(1);

        // Reset asserted after two bytes of a load
        $display("[TB] reset during RECV");
        startLoad();
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        #2 reset = 1'b1;
        #1 checkResetValues(7'h33);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Two-word HALT load, with a stray load_start between the words
        $display("[TB] two-word HALT load");
        startLoad();
        cpu_addr = 7'h55;
        checkOutput("busy_in_load", {31'd0, busy}, 32'd1);
        checkOutput("addr_ignores_cpu", {25'd0, mem_addr}, 32'd0);
        sendWord(7'd0, 32'h20080005, 1);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checkOutput("busy_after_stray_start", {31'd0, busy}, 32'd1);
        checkOutput("addr_after_stray_start", {25'd0, mem_addr}, 32'd1);
        sendWord(7'd1, 32'hFC000000, 1);
        finishHalt(1'b1);
        waitDone(20);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("word_count_2", {24'd0, word_count}, 32'd2);
        checkOutput("ovf_halt", {31'd0, ovf}, 32'd0);
        checkOutput("chk_err_good", {31'd0, chk_err}, 32'd0);
        cpu_addr = 7'h05;
        #1 checkOutput("addr_follows_cpu", {25'd0, mem_addr}, 32'h05);
        idle(2);

`ifdef LOADER_CHECKSUM_EN
        // The same load with a wrong trailing byte (00; the XOR of the eight bytes is D1)
        $display("[TB] checksum mismatch");
        startLoad();
        sendWord(7'd0, 32'h20080005, 1);
        sendWord(7'd1, 32'hFC000000, 1);
        idle(5);
        checkOutput("done_before_bad_chk", {31'd0, load_done}, 32'd0);
        applyStimulus(8'h00);
        waitDone(20);
        checkOutput("chk_err_bad", {31'd0, chk_err}, 32'd1);
        idle(2);
`endif

        // Back-to-back bytes, one on every clock
        $display("[TB] back-to-back bytes");
        startLoad();
        sendWord(7'd0, 32'h11223344, 0);
        sendWord(7'd1, 32'h55667788, 0);
        sendWord(7'd2, 32'h99AABBCC, 0);
        sendWord(7'd3, 32'hFC000001, 0);
        finishHalt(1'b1);
        waitDone(40);
        checkOutput("word_count_4", {24'd0, word_count}, 32'd4);
        checkOutput("ovf_b2b", {31'd0, ovf}, 32'd0);
        checkOutput("chk_err_b2b", {31'd0, chk_err}, 32'd0);
        idle(2);

        // 128 non-HALT words fill the memory
        $display("[TB] overflow load");
        startLoad();
        for (int i = 0; i < 128; i++) begin
            sendWord(7'(i), 32'h00000000, 0);
        end
        waitDone(20);
        checkOutput("ovf_set", {31'd0, ovf}, 32'd1);
        checkOutput("word_count_128", {24'd0, word_count}, 32'd128);
        checkOutput("busy_ovf", {31'd0, busy}, 32'd0);
        checkOutput("chk_err_ovf", {31'd0, chk_err}, 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(8'h00);
        idle(10);
        checkOutput("no_write_after_ovf", exp_q.size(), 32'd0);
        checkOutput("load_done_stays", {31'd0, load_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guards against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=expired required=finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
